mem_stream_reader: RTL and testbench

Read-side master for the synchronous single-port-read data memory: walks a block of addresses, absorbs the memory's one-cycle registered read latency, and presents the words as a valid/ready stream. The matrix-multiply datapath uses it to fetch operand rows and columns from data memory. It drives only the memory's read address and consumes its read data. The write port is untouched.

---
 rtl/mem_stream_reader.sv | 166 ++++++++++++++++
 tb/tb_mem_stream_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Read-side master: walks an address block on a registered-read memory and streams the words.
// Optional MEM_READER_STRIDE_EN adds a stride port; otherwise the address step is fixed at 1.
module mem_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
`ifdef MEM_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRead   = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] step;
    logic [2:0]            occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;

`ifdef MEM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (state_q == StIdle && start) begin
            step_d = stride;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    assign m_valid    = (count_q != 2'd0);
    assign m_data     = fifo_q[rd_ptr_q];
    assign m_last     = m_valid && (beat_q == (len_q - LEN_WIDTH'(1)));
    assign pop        = m_valid && m_ready;
    assign push       = inflight_q;
    assign mem_r_addr = addr_q;
    assign busy       = (state_q == StRead) || (state_q == StDrain);
    assign done       = (state_q == StFinish);

    // Words already buffered plus the one in flight, net of this cycle's pop, must leave a slot.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == StRead) && (issued_q < len_q) && (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = issue;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = len;
                    issued_d = '0;
                    beat_d   = '0;
                    state_d  = (len == '0) ? StFinish : StRead;
                end
            end
            StRead: begin
                if (issue && (issued_q == (len_q - LEN_WIDTH'(1)))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && m_last) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (issue) begin
            addr_d   = addr_q + step;
            issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (pop) begin
            beat_d = beat_q + LEN_WIDTH'(1);
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            fifo_d[wr_ptr_q] = mem_r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a registered-read memory holding mem[i] = i.
module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] len;
`ifdef MEM_READER_STRIDE_EN
    logic [7:0] stride;
`endif
    logic       busy;
    logic       done;
    logic [7:0] mem_r_addr;
    logic [7:0] mem_r_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    logic [7:0] mem [256];
    int         n_cmp  = 0;
    int         n_fail = 0;

    mem_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
`ifdef MEM_READER_STRIDE_EN
        .stride     (stride),
`endif
        .busy       (busy),
        .done       (done),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_r_data <= mem[mem_r_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(mem_r_addr), 32'h0);
        check({tag, "_data"}, 32'(m_data), 32'h0);
        check({tag, "_valid"}, 32'(m_valid), 32'h0);
        check({tag, "_last"}, 32'(m_last), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0 repeating.
    task automatic run_xfer(input logic [7:0] base, input int n, input logic [7:0] step,
                            input int mode);
        int         idx = 0;
        int         ndone = 0;
        int         first = -1;
        int         lastc = -1;
        int         donec = -1;
        bit         busy_seen = 0;
        logic [7:0] e;
        start     = 1'b1;
        base_addr = base;
        len       = 9'(n);
`ifdef MEM_READER_STRIDE_EN
        stride    = step;
`endif
        tick();
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (donec >= 0) begin
                check("done_pulse_width", 32'(done), 32'h0);
                break;
            end
            m_ready = (mode == 0) ? 1'b1 : ((c % 3) == 1);
            if (c == 1 && n != 0) check("first_addr", 32'(mem_r_addr), 32'(base));
            if (busy) busy_seen = 1;
            if (m_valid) begin
                if (idx < n) begin
                    e = base + 8'(idx) * step;
                    check("beat_data", 32'(m_data), 32'(e));
                    check("beat_last", 32'(m_last), 32'(idx == n - 1));
                end else begin
                    check("extra_beat", 32'(m_valid), 32'h0);
                end
                if (first < 0) first = c;
                if (m_ready) begin
                    if (m_last) lastc = c;
                    idx++;
                end
            end
            if (done) begin
                ndone++;
                donec = c;
            end
            tick();
        end
        check("beat_count", 32'(idx), 32'(n));
        check("done_count", 32'(ndone), 32'h1);
        check("busy_seen", 32'(busy_seen), 32'(n != 0));
        if (n == 0) begin
            check("len0_done_cycle", 32'(donec), 32'h1);
        end else begin
            check("done_after_last", 32'(donec), 32'(lastc + 1));
            if (mode == 0) begin
                check("first_valid_cycle", 32'(first), 32'h3);
                check("last_beat_cycle", 32'(lastc), 32'(n + 2));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 8'h0;
        len       = 9'h0;
        m_ready   = 1'b1;
`ifdef MEM_READER_STRIDE_EN
        stride    = 8'h1;
`endif
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_xfer(8'h10, 4, 8'h01, 0);
        run_xfer(8'hFE, 4, 8'h01, 0);
        run_xfer(8'h30, 8, 8'h01, 1);
        run_xfer(8'h40, 0, 8'h01, 0);

        // Abort a len-8 transfer after three beats have been accepted.
        start     = 1'b1;
        base_addr = 8'h00;
        len       = 9'd8;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_third_beat", 32'(m_data), 32'h02);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("post_reset_done", 32'(done), 32'h0);
            check("post_reset_valid", 32'(m_valid), 32'h0);
            tick();
        end
        run_xfer(8'h20, 2, 8'h01, 0);

`ifdef MEM_READER_STRIDE_EN
        run_xfer(8'h01, 3, 8'h04, 0);
        run_xfer(8'h07, 3, 8'h00, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
